// File: rtl/uart_rx_gen.sv
// Oversampling UART receiver: 2-flop sync, 3-sample majority per bit, optional parity, break detect.
// Word lands in the holding register the cycle after the last stop decision; rts=1 while unqualified or full.
module uart_rx_gen #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_BITS    = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rts,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack_n,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int   H        = CLKS_PER_BIT / 2;
  localparam int   IDLE_LEN = IDLE_BITS * CLKS_PER_BIT;
  localparam int   CW       = $clog2(CLKS_PER_BIT);
  localparam int   IW       = $clog2(IDLE_LEN + 1);
  localparam logic ODD      = (PARITY == 2);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_sync;
  logic [IW-1:0]          idle_cnt;
  logic [CW-1:0]          bit_cnt;
  logic [3:0]             bit_idx;
  logic                   smp0, smp1;
  logic [DATA_BITS-1:0]   shreg;
  logic                   all_zero, par_bad, stop_bad;
  logic                   decide, maj, zero_now, frame_now;
  logic                   deliver, brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign decide    = (bit_cnt == CW'(H + 1));
  assign maj       = (smp0 & smp1) | (smp0 & rx_sync) | (smp1 & rx_sync);
  // Break and frame status including the bit being decided right now.
  assign zero_now  = all_zero & ~maj;
  assign frame_now = stop_bad | ~maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deliver   = 1'b0;
    brk       = 1'b0;
    case (state)
      S_INIT:  if (rx_sync && idle_cnt == IW'(IDLE_LEN - 1)) state_nxt = S_IDLE;
      S_IDLE:  if (!rx_sync) state_nxt = S_START;
      S_START: if (decide) state_nxt = maj ? S_IDLE : S_DATA;
      S_DATA:  if (decide && bit_idx == 4'(DATA_BITS - 1))
                 state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (decide) state_nxt = S_STOP;
      S_STOP:  if (decide && bit_idx == 4'(STOP_BITS - 1)) begin
                 if (zero_now) begin
                   brk       = 1'b1;
                   state_nxt = S_INIT;
                 end else begin
                   deliver   = 1'b1;
                   state_nxt = frame_now ? S_INIT : S_IDLE;
                 end
               end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      smp0     <= 1'b0;
      smp1     <= 1'b0;
      shreg    <= '0;
      all_zero <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      idle_cnt <= (state == S_INIT && rx_sync) ? idle_cnt + 1'b1 : '0;
      // The falling edge seen in IDLE is count 0 of the start bit.
      if (state == S_IDLE)
        bit_cnt <= rx_sync ? '0 : CW'(1);
      else if (state != S_INIT)
        bit_cnt <= (bit_cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : bit_cnt + 1'b1;
      else
        bit_cnt <= '0;
      if (bit_cnt == CW'(H - 1)) smp0 <= rx_sync;
      if (bit_cnt == CW'(H))     smp1 <= rx_sync;
      if (state_nxt != state)
        bit_idx <= '0;
      else if (decide && (state == S_DATA || state == S_STOP))
        bit_idx <= bit_idx + 1'b1;
      if (decide) begin
        case (state)
          S_START: begin
            all_zero <= 1'b1;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end
          S_DATA: begin
            shreg    <= {maj, shreg[DATA_BITS-1:1]};
            all_zero <= zero_now;
          end
          S_PAR: begin
            par_bad  <= (^shreg) ^ maj ^ ODD;
            all_zero <= zero_now;
          end
          S_STOP: begin
            stop_bad <= frame_now;
            all_zero <= zero_now;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts        <= 1'b1;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      break_det <= brk;
      rts       <= (state == S_INIT) || data_valid;
      if (deliver) begin
        // A coincident ack frees the register, so the new word wins.
        if (!data_valid || !data_ack_n) begin
          data       <= shreg;
          data_valid <= 1'b1;
          parity_err <= par_bad;
          frame_err  <= frame_now;
          overrun    <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && !data_ack_n) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_gen.sv
// Randomized bench for uart_rx_gen: frame-level reference model with per-cycle compare, plus pinned literal checks.
module tb_uart_rx_gen;

  localparam int CA       = 32;
  localparam int CB       = 16;
  localparam int IDLE_LEN = 9 * CA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, ack_n_a = 1'b1;
  logic rx_b = 1'b1, ack_n_b = 1'b1;
  logic rts_a, dv_a, pe_a, fe_a, ov_a, bd_a;
  logic rts_b, dv_b, pe_b, fe_b, ov_b, bd_b;
  logic [7:0] data_a, data_b;

  uart_rx_gen dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rts(rts_a), .data(data_a), .data_valid(dv_a),
    .data_ack_n(ack_n_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .break_det(bd_a)
  );

  uart_rx_gen #(.CLKS_PER_BIT(CB), .PARITY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rts(rts_b), .data(data_b), .data_valid(dv_b),
    .data_ack_n(ack_n_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .break_det(bd_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected receptions: cycle count at which the holding register must show the result.
  typedef struct {
    int         t;
    logic [7:0] w;
    logic       fe;
    logic       brk;
  } ev_t;
  ev_t ev_mem [128];
  int  wr_ptr = 0;
  int  rd_ptr = 0;

  logic       m_valid = 0, m_perr = 0, m_ferr = 0, m_ovr = 0, m_brk = 0;
  logic [7:0] m_data = 0;
  logic       m_ack, m_dlv;
  ev_t        cur_ev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_brk = 0;
      rd_ptr  = wr_ptr;
    end else begin
      m_brk = 0;
      m_dlv = 0;
      m_ack = !ack_n_a;
      if (rd_ptr != wr_ptr && ev_mem[rd_ptr].t == cyc + 1) begin
        cur_ev = ev_mem[rd_ptr];
        rd_ptr = rd_ptr + 1;
        if (cur_ev.brk) m_brk = 1;
        else            m_dlv = 1;
      end
      if (m_dlv) begin
        if (!m_valid || m_ack) begin
          m_valid = 1; m_data = cur_ev.w; m_perr = 0; m_ferr = cur_ev.fe; m_ovr = 0;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && m_ack) begin
        m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      end
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   bd_cnt  = 0;
  logic ack_rand = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Every cycle advance goes through here so dut_a is compared against the model each cycle.
  task automatic tick();
    @(negedge clk);
    if (ack_rand) ack_n_a = ($urandom_range(0, 7) != 0);
    chk("cycle_flags", {dv_a, pe_a, fe_a, ov_a, bd_a}, {m_valid, m_perr, m_ferr, m_ovr, m_brk});
    if (m_valid) chk("cycle_data", data_a, m_data);
    if (bd_a) bd_cnt++;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    repeat (n) begin
      tick();
      if (sel) rx_b = v;
      else     rx_a = v;
    end
  endtask

  task automatic send_a(input logic [7:0] w, input logic stop);
    int c0;
    tick();
    c0 = cyc;
    rx_a = 0;
    ev_mem[wr_ptr].t   = c0 + 3 + 9 * CA + CA / 2 + 1;
    ev_mem[wr_ptr].w   = w;
    ev_mem[wr_ptr].fe  = !stop;
    ev_mem[wr_ptr].brk = (w == 8'h00) && !stop;
    wr_ptr++;
    repeat (CA - 1) tick();
    for (int i = 0; i < 8; i++) drive(0, w[i], CA);
    drive(0, stop, CA);
  endtask

  task automatic ack_a();
    tick(); ack_n_a = 0;
    tick(); ack_n_a = 1;
  endtask

  task automatic send_check_b(input logic [7:0] w, input logic p);
    drive(1, 0, CB);
    for (int i = 0; i < 8; i++) drive(1, w[i], CB);
    drive(1, p, CB);
    drive(1, 1, CB + 4);
    chk("b_valid", dv_b, 1);
    chk("b_data", data_b, w);
    chk("b_perr", pe_b, ($countones(w) + p) % 2);
    chk("b_fe_ov_bd", {fe_b, ov_b, bd_b}, 0);
    tick(); ack_n_b = 0;
    tick(); ack_n_b = 1;
    chk("b_cleared", {dv_b, pe_b}, 0);
  endtask

  initial begin
    int r, c0, c1;
    logic [7:0] w;
    logic stop;

    repeat (3) tick();
    chk("rst_rts", rts_a, 1);
    chk("rst_data", data_a, 0);
    chk("rst_flags", {dv_a, pe_a, fe_a, ov_a, bd_a}, 0);
    chk("rst_rts_b", rts_b, 1);
    tick(); rst_n = 1; r = cyc;
    tick_to(r + 288);
    chk("qual_rts_hi", rts_a, 1);
    tick();
    chk("qual_rts_lo", rts_a, 0);

    send_a(8'hA5, 1);
    drive(0, 1, 4);
    chk("a5_data", data_a, 8'hA5);
    chk("a5_valid", dv_a, 1);
    chk("a5_flags", {pe_a, fe_a, ov_a}, 0);
    ack_a();
    chk("a5_acked", dv_a, 0);

    drive(0, 0, 8);
    drive(0, 1, 40);
    chk("glitch_valid", dv_a, 0);
    chk("glitch_rts", rts_a, 0);

    send_a(8'h11, 1);
    drive(0, 1, 3);
    send_a(8'h22, 1);
    drive(0, 1, 3);
    chk("ovr_data", data_a, 8'h11);
    chk("ovr_flag", ov_a, 1);
    chk("ovr_rts", rts_a, 1);
    ack_a();
    chk("ovr_cleared", {dv_a, ov_a}, 0);

    ack_rand = 1;
    for (int i = 0; i < 24; i++) begin
      w    = (i % 8 == 5) ? 8'h00 : 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_a(w, stop);
      if (!stop) drive(0, 1, IDLE_LEN + CA + 8);
      else       drive(0, 1, $urandom_range(1, 30));
    end
    ack_rand = 0;
    ack_n_a  = 1;
    ack_a();
    chk("rand_drained", dv_a, 0);
    drive(0, 1, 4);

    bd_cnt = 0;
    tick();
    c0 = cyc;
    rx_a = 0;
    ev_mem[wr_ptr].t   = c0 + 3 + 9 * CA + CA / 2 + 1;
    ev_mem[wr_ptr].w   = 8'h00;
    ev_mem[wr_ptr].fe  = 1;
    ev_mem[wr_ptr].brk = 1;
    wr_ptr++;
    repeat (12 * CA - 1) tick();
    tick();
    c1 = cyc;
    rx_a = 1;
    tick_to(c1 + 290);
    chk("brk_pulses", bd_cnt, 1);
    chk("brk_valid", dv_a, 0);
    chk("brk_rts_hi", rts_a, 1);
    tick();
    chk("brk_rts_lo", rts_a, 0);

    send_a(8'h5A, 1);
    drive(0, 1, 4);
    chk("pre_rst_data", data_a, 8'h5A);
    drive(0, 0, CA);
    drive(0, 1, CA);
    drive(0, 0, CA);
    drive(0, 1, CA / 2);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rts", rts_a, 1);
    chk("mid_rst_data", data_a, 0);
    chk("mid_rst_flags", {dv_a, pe_a, fe_a, ov_a, bd_a}, 0);
    rx_a = 1;
    tick();
    tick(); rst_n = 1; r = cyc;
    tick_to(r + 288);
    chk("requal_rts_hi", rts_a, 1);
    tick();
    chk("requal_rts_lo", rts_a, 0);
    send_a(8'h3C, 1);
    drive(0, 1, 4);
    chk("post_rst_data", data_a, 8'h3C);
    chk("post_rst_valid", dv_a, 1);
    ack_a();

    send_check_b(8'h07, 0);
    chk("b07_p0_perr_lit", pe_b, 0);
    drive(1, 0, CB);
    for (int i = 0; i < 8; i++) drive(1, i < 3, CB);
    drive(1, 0, CB);
    drive(1, 1, CB + 4);
    chk("b07_p0_err", pe_b, 1);
    tick(); ack_n_b = 0;
    tick(); ack_n_b = 1;
    send_check_b(8'h07, 1);
    for (int i = 0; i < 6; i++)
      send_check_b(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
